// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types, constants and the hex-to-segment table
// for the four-digit scanned seven-segment display.
package seg7_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } word_t;

  // seg[0:6] = a..g, active-low
  function automatic logic [0:6] hex2seg(
    input logic [3:0] h
  );
    logic [0:6] s;
    unique case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Digit i is a leading zero when nibbles i..3 are all zero
  function automatic logic lz_zero(
    input logic [15:0] v,
    input logic [1:0]  i
  );
    logic z;
    unique case (i)
      2'd0: z = 1'b0;
      2'd1: z = (v[15:4] == 12'h000);
      2'd2: z = (v[15:8] == 8'h00);
      2'd3: z = (v[15:12] == 4'h0);
    endcase
    return z;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-word load port and board display pins
// of the seven-segment scan controller.
interface seg7_scan_ctrl_if;

  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_blank;
  logic        load_ack;
  logic        frame_done;
  logic [3:0]  an;
  logic [0:6]  seg;
  logic        dp;

  modport master (
    output load, value_in, dp_in,
    output blank_in, lz_blank,
    input  load_ack, frame_done,
    input  an, seg, dp
  );

  modport slave (
    input  load, value_in, dp_in,
    input  blank_in, lz_blank,
    output load_ack, frame_done,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-low
// seven-segment code.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [0:6] seg_o
);

  assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit scan controller: guard/drive FSM,
// frame-boundary word commit and digit blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000,
  parameter int GUARD_TICKS = 1_000
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int MAXT =
    (DIGIT_TICKS > GUARD_TICKS) ?
    DIGIT_TICKS : GUARD_TICKS;
  localparam int CW =
    (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] D_LAST =
    CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] G_LAST =
    CW'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);
  localparam state_e ST_IDLE =
    (GUARD_TICKS == 0) ? ST_DRIVE : ST_GUARD;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  word_t         act_q, pend_q;
  logic          pend_v_q;
  logic [3:0]    an_q;
  logic [0:6]    seg_q;
  logic          dp_q, ack_q, fd_q;

  logic          drive, commit, blank;
  logic [3:0]    nib;
  logic [0:6]    dec_seg;

  assign drive  = (state_q == ST_DRIVE);
  assign commit = drive && (idx_q == 2'd3) &&
                  (cnt_q == D_LAST);
  assign nib    = act_q.val[{idx_q, 2'b00} +: 4];
  assign blank  = act_q.blank[idx_q] |
                  (bus.lz_blank &
                   lz_zero(act_q.val, idx_q));

  seg7_hex_decode u_dec (
    .hex_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      ST_GUARD: begin
        if (cnt_q == G_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == D_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      act_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= drive ?
                 ~(4'b0001 << idx_q) : AN_OFF;
      seg_q   <= (drive && !blank) ?
                 dec_seg : SEG_BLANK;
      dp_q    <= !(drive && !blank &&
                   act_q.dp[idx_q]);
      fd_q    <= commit;
      ack_q   <= commit && pend_v_q;
      if (commit && pend_v_q)
        act_q <= pend_q;
      // a load in the commit cycle stays pending
      if (bus.load) begin
        pend_q   <= '{val:   bus.value_in,
                      dp:    bus.dp_in,
                      blank: bus.blank_in};
        pend_v_q <= 1'b1;
      end else if (commit) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with
// DIGIT_TICKS=8, GUARD_TICKS=2 and a no-guard twin.
module tb_seg7_scan_ctrl;

  localparam logic [0:6] BL = 7'b1111111;
  localparam logic [0:6] S0 = 7'b0000001;
  localparam logic [0:6] S1 = 7'b1001111;
  localparam logic [0:6] S2 = 7'b0010010;
  localparam logic [0:6] S3 = 7'b0000110;
  localparam logic [0:6] S5 = 7'b0100100;
  localparam logic [0:6] SA = 7'b0001000;
  localparam logic [0:6] SF = 7'b0111000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vecs  = 0;
  int   errs  = 0;

  logic [3:0] an_c  [40];
  logic [0:6] seg_c [40];
  logic       dp_c  [40];
  logic       fd_c  [40];
  logic       ack_c [40];

  seg7_scan_ctrl_if bus ();
  seg7_scan_ctrl_if bus2 ();

  seg7_scan_ctrl #(
    .DIGIT_TICKS (8),
    .GUARD_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg7_scan_ctrl #(
    .DIGIT_TICKS (8),
    .GUARD_TICKS (0)
  ) dut_ng (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(
    input logic [15:0] v,
    input logic [3:0]  d,
    input logic [3:0]  b
  );
    bus.value_in = v;
    bus.dp_in    = d;
    bus.blank_in = b;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic wait_fd(
    output bit ok,
    output int acks
  );
    ok   = 1'b0;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.load_ack === 1'b1) acks++;
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cap_frame;
    for (int k = 0; k < 40; k++) begin
      step();
      an_c[k]  = bus.an;
      seg_c[k] = bus.seg;
      dp_c[k]  = bus.dp;
      fd_c[k]  = bus.frame_done;
      ack_c[k] = bus.load_ack;
    end
  endtask

  function automatic logic [11:0] exp_px(
    input int              k,
    input logic [3:0][0:6] es,
    input logic [3:0]      edp
  );
    int d = k / 10;
    if (k % 10 < 2) return {4'b1111, BL, 1'b1};
    return {~(4'b0001 << d), es[d], edp[d]};
  endfunction

  task automatic test_reset;
    bit ok;
    int acks;
    bus.load = 0; bus.value_in = 0;
    bus.dp_in = 0; bus.blank_in = 0;
    bus.lz_blank = 0;
    bus2.load = 0; bus2.value_in = 0;
    bus2.dp_in = 0; bus2.blank_in = 0;
    bus2.lz_blank = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({bus.an, bus.seg, bus.dp, bus.load_ack,
         bus.frame_done} !== {4'b1111, BL, 3'b100}) begin
      errs++;
      $display("FAIL reset_vals got %b%b%b%b%b",
        bus.an, bus.seg, bus.dp, bus.load_ack,
        bus.frame_done);
    end
    rst_n = 1'b1;
    repeat (5) step();
    vecs++;
    if (bus.an !== 4'b1110) begin
      errs++;
      $display("FAIL first_drive an=%b exp 1110", bus.an);
    end
    pulse(16'hBEEF, 4'b1111, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.an, bus.seg, bus.dp, bus.load_ack,
         bus.frame_done} !== {4'b1111, BL, 3'b100}) begin
      errs++;
      $display("FAIL async_reset got %b%b%b%b%b",
        bus.an, bus.seg, bus.dp, bus.load_ack,
        bus.frame_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if (bus.an !== 4'b1111) begin
        errs++;
        $display("FAIL rel_guard%0d an=%b exp 1111",
          i, bus.an);
      end
    end
    step();
    vecs++;
    if ({bus.an, bus.seg, bus.dp} !==
        {4'b1110, S0, 1'b1}) begin
      errs++;
      $display("FAIL rel_drive got %b %b %b exp 1110 %b 1",
        bus.an, bus.seg, bus.dp, S0);
    end
    wait_fd(ok, acks);
    vecs++;
    if (!ok || acks != 0) begin
      errs++;
      $display("FAIL discard ok=%0d acks=%0d exp 1 0",
        ok, acks);
    end
  endtask

  task automatic test_load_display;
    bit ok;
    int acks, n;
    logic [3:0][0:6] es;
    pulse(16'h12AF, 4'b0100, 4'b0000);
    wait_fd(ok, acks);
    vecs++;
    if (!ok || acks != 1) begin
      errs++;
      $display("FAIL load_ack ok=%0d acks=%0d exp 1 1",
        ok, acks);
    end
    cap_frame();
    es[0] = SF; es[1] = SA; es[2] = S2; es[3] = S1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      n += int'(ack_c[k]);
      vecs++;
      if ({an_c[k], seg_c[k], dp_c[k]} !==
          exp_px(k, es, 4'b1011)) begin
        errs++;
        $display("FAIL load_px%0d got %b exp %b", k,
          {an_c[k], seg_c[k], dp_c[k]},
          exp_px(k, es, 4'b1011));
      end
    end
    vecs++;
    if (fd_c[39] !== 1'b1 || n != 0) begin
      errs++;
      $display("FAIL load_frame fd=%b acks=%0d exp 1 0",
        fd_c[39], n);
    end
  endtask

  task automatic test_lz_blank;
    bit ok;
    int acks;
    logic [3:0][0:6] es;
    bus.lz_blank = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pulse((p == 0) ? 16'h0005 : 16'h0000,
            4'b0000, 4'b0000);
      wait_fd(ok, acks);
      vecs++;
      if (!ok || acks != 1) begin
        errs++;
        $display("FAIL lz_ack%0d ok=%0d acks=%0d", p,
          ok, acks);
      end
      cap_frame();
      es[0] = (p == 0) ? S5 : S0;
      es[1] = BL; es[2] = BL; es[3] = BL;
      for (int k = 0; k < 40; k++) begin
        vecs++;
        if ({an_c[k], seg_c[k], dp_c[k]} !==
            exp_px(k, es, 4'b1111)) begin
          errs++;
          $display("FAIL lz%0d_px%0d got %b exp %b", p, k,
            {an_c[k], seg_c[k], dp_c[k]},
            exp_px(k, es, 4'b1111));
        end
      end
    end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acks, n;
    logic [3:0][0:6] es;
    pulse(16'h1111, 4'b0000, 4'b0000);
    repeat (3) step();
    pulse(16'h2222, 4'b0000, 4'b0000);
    acks = 0;
    for (int t = 5; t < 39; t++) begin
      step();
      if (bus.load_ack === 1'b1) acks++;
    end
    pulse(16'h3333, 4'b0000, 4'b0000);
    vecs++;
    if (acks != 0 || bus.frame_done !== 1'b1 ||
        bus.load_ack !== 1'b1) begin
      errs++;
      $display("FAIL b2b_commit early=%0d fd=%b ack=%b",
        acks, bus.frame_done, bus.load_ack);
    end
    for (int f = 0; f < 2; f++) begin
      cap_frame();
      es[0] = (f == 0) ? S2 : S3;
      es[1] = es[0]; es[2] = es[0]; es[3] = es[0];
      n = 0;
      for (int k = 0; k < 40; k++) begin
        n += int'(ack_c[k]);
        vecs++;
        if ({an_c[k], seg_c[k], dp_c[k]} !==
            exp_px(k, es, 4'b1111)) begin
          errs++;
          $display("FAIL b2b%0d_px%0d got %b exp %b", f, k,
            {an_c[k], seg_c[k], dp_c[k]},
            exp_px(k, es, 4'b1111));
        end
      end
      vecs++;
      if (n != 1 - f || ack_c[39] !== 1'(1 - f)) begin
        errs++;
        $display("FAIL b2b%0d_acks got %0d exp %0d",
          f, n, 1 - f);
      end
    end
  endtask

  task automatic test_blank_dp;
    bit ok;
    int acks;
    logic [3:0][0:6] es;
    pulse(16'h4321, 4'b1111, 4'b1010);
    wait_fd(ok, acks);
    vecs++;
    if (!ok || acks != 1) begin
      errs++;
      $display("FAIL bdp_ack ok=%0d acks=%0d", ok, acks);
    end
    cap_frame();
    es[0] = S1; es[1] = BL; es[2] = S3; es[3] = BL;
    for (int k = 0; k < 40; k++) begin
      vecs++;
      if ({an_c[k], seg_c[k], dp_c[k]} !==
          exp_px(k, es, 4'b1010)) begin
        errs++;
        $display("FAIL bdp_px%0d got %b exp %b", k,
          {an_c[k], seg_c[k], dp_c[k]},
          exp_px(k, es, 4'b1010));
      end
    end
  endtask

  task automatic test_no_guard;
    bit ok = 1'b0;
    logic [12:0] ex;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus2.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL ng_sync timeout");
    end
    for (int k = 0; k < 32; k++) begin
      step();
      ex = {~(4'b0001 << (k / 8)), S0, 1'b1,
            1'(k == 31)};
      vecs++;
      if ({bus2.an, bus2.seg, bus2.dp,
           bus2.frame_done} !== ex) begin
        errs++;
        $display("FAIL ng_px%0d got %b exp %b", k,
          {bus2.an, bus2.seg, bus2.dp,
           bus2.frame_done}, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_lz_blank();
    test_back_to_back();
    test_blank_dp();
    test_no_guard();
    $display("== %0d vectors applied, %0d miscompares ==",
      vecs, errs);
    $finish;
  end

endmodule
